// File: rtl/seq_source_pkg.sv
// Shared encodings and defaults for the seq_source stimulus stage.
package seq_source_pkg;

    localparam logic [1:0] MODE_CNT   = 2'b00;
    localparam logic [1:0] MODE_LFSR  = 2'b01;
    localparam logic [1:0] MODE_CONST = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Maximal-length Fibonacci tap masks for the common widths; other widths get x^n+x^(n-1)+1.
    function automatic logic [15:0] default_taps(input int unsigned width);
        logic [15:0] taps;
        case (width)
            4:       taps = 16'h000C;
            8:       taps = 16'h00B8;
            16:      taps = 16'hD008;
            default: taps = (16'(1) << (width - 1)) | (16'(1) << (width - 2));
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// One-step Fibonacci LFSR advance: shift left, feed back the parity of the tapped bits.
module lfsr_next #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_state,
    input  logic [WIDTH-1:0] i_taps,
    output logic [WIDTH-1:0] o_next_c
);

    assign o_next_c = {i_state[WIDTH-2:0], ^(i_state & i_taps)};

endmodule

// File: rtl/seq_source.sv
// Programmable counter/LFSR/constant sample source with valid/ready output and burst control.
module seq_source
    import seq_source_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 4,
    parameter int unsigned          LEN_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS = DATA_WIDTH'(default_taps(DATA_WIDTH))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [DATA_WIDTH-1:0] step,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  beat_cnt
);

    state_t                r_state;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_step;
    logic [LEN_WIDTH-1:0]  r_length;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_done;
    logic [LEN_WIDTH-1:0]  r_beat_cnt;

    state_t                w_state;
    logic [1:0]            w_mode;
    logic [DATA_WIDTH-1:0] w_step;
    logic [LEN_WIDTH-1:0]  w_length;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_valid;
    logic                  w_busy;
    logic                  w_done;
    logic [LEN_WIDTH-1:0]  w_beat_cnt;

    logic                  w_xfer;
    logic                  w_last;
    logic [LEN_WIDTH-1:0]  w_cnt_inc;
    logic [DATA_WIDTH-1:0] w_lfsr_data;
    logic [DATA_WIDTH-1:0] w_adv_data;
    logic [DATA_WIDTH-1:0] w_launch_data;

    lfsr_next #(
        .WIDTH (DATA_WIDTH)
    ) u_lfsr_next (
        .i_state  (r_data),
        .i_taps   (LFSR_TAPS),
        .o_next_c (w_lfsr_data)
    );

    // Datapath helpers: transfer detect, saturating beat count, next sample per mode.
    always_comb begin
        w_xfer    = r_valid & out_ready;
        w_cnt_inc = (r_beat_cnt == '1) ? r_beat_cnt : r_beat_cnt + LEN_WIDTH'(1);
        w_last    = (r_length != '0) && (w_cnt_inc == r_length);
        case (r_mode)
            MODE_LFSR:  w_adv_data = w_lfsr_data;
            MODE_CONST: w_adv_data = r_data;
            default:    w_adv_data = r_data + r_step;
        endcase
        // An all-zero LFSR state would never leave zero, so substitute 1.
        w_launch_data = ((mode == MODE_LFSR) && (seed == '0)) ? DATA_WIDTH'(1) : seed;
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state    = r_state;
        w_mode     = r_mode;
        w_step     = r_step;
        w_length   = r_length;
        w_data     = r_data;
        w_valid    = r_valid;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_beat_cnt = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_state    = RUN;
                    w_mode     = mode;
                    w_step     = step;
                    w_length   = length;
                    w_data     = w_launch_data;
                    w_valid    = 1'b1;
                    w_busy     = 1'b1;
                    w_beat_cnt = '0;
                end
            end
            RUN: begin
                if (w_xfer) begin
                    w_beat_cnt = w_cnt_inc;
                    w_data     = w_adv_data;
                end
                if ((w_xfer && w_last) || stop) begin
                    w_state = IDLE;
                    w_valid = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = w_xfer && w_last;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mode     <= MODE_CNT;
            r_step     <= '0;
            r_length   <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_mode     <= w_mode;
            r_step     <= w_step;
            r_length   <= w_length;
            r_data     <= w_data;
            r_valid    <= w_valid;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_beat_cnt <= w_beat_cnt;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign beat_cnt  = r_beat_cnt;

endmodule
